// File: rtl/clk_gen_pkg.sv
// Shared types and constants for the PLL-downstream reset and clock-enable generator.
// Imported by the top level and by the divider.
package clk_gen_pkg;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        WAIT = 2'd1,
        RUN  = 2'd2
    } state_e;

    localparam int LOCK_WAIT_DEF = 1024;
    localparam int BASE_DIV_DEF  = 6;
    localparam int DIV_W         = 4;

    // Enables are ordered slowest-first so the packed vector reads 1M..16M.
    typedef struct packed {
        logic ce_1m;
        logic ce_2m;
        logic ce_4m;
        logic ce_8m;
        logic ce_16m;
    } ce_t;

    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/clk_reset_ce_gen_if.sv
// Lock, soft-reset, core-reset and clock-enable signals between the generator and the core.
// The generator takes the master side; the core takes the slave side.
interface clk_reset_ce_gen_if;

    logic locked;
    logic ext_rst;
    logic sys_rst;
    logic ce_16m;
    logic ce_8m;
    logic ce_4m;
    logic ce_2m;
    logic ce_1m;

    modport master (
        input  locked, ext_rst,
        output sys_rst, ce_16m, ce_8m, ce_4m, ce_2m, ce_1m
    );

    modport slave (
        output locked, ext_rst,
        input  sys_rst, ce_16m, ce_8m, ce_4m, ce_2m, ce_1m
    );

endinterface

// File: rtl/clk_reset_ce_gen_ce_divider.sv
// Phase-aligned single-cycle clock enables at 16/8/4/2/1 MHz, derived from one base counter.
// The divider phase restarts at zero every time run rises.
module ce_divider
    import clk_gen_pkg::*;
#(
    parameter int BASE_DIV = BASE_DIV_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output ce_t  ce
);

    localparam int            BW        = cnt_width(BASE_DIV);
    localparam logic [BW-1:0] BASE_LAST = BW'(BASE_DIV - 1);

    logic [BW-1:0]    base_cnt_q, base_cnt_d;
    logic [DIV_W-1:0] div_cnt_q,  div_cnt_d;
    ce_t              ce_q,       ce_d;
    logic             hit;

    // run is the next-cycle RUN flag, so the enables drop on the same edge that raises sys_rst.
    always_comb begin
        // NOTE: every always_comb output gets a default first; a missed branch would otherwise infer a latch.
        base_cnt_d = '0;
        div_cnt_d  = '0;
        ce_d       = '0;
        hit        = 1'b0;
        if (run) begin
            hit         = (base_cnt_q == BASE_LAST);
            base_cnt_d  = hit ? '0 : base_cnt_q + 1'b1;
            div_cnt_d   = hit ? div_cnt_q + 1'b1 : div_cnt_q;
            ce_d.ce_16m = hit;
            ce_d.ce_8m  = hit & div_cnt_q[0];
            ce_d.ce_4m  = hit & (&div_cnt_q[1:0]);
            ce_d.ce_2m  = hit & (&div_cnt_q[2:0]);
            ce_d.ce_1m  = hit & (&div_cnt_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_cnt_q <= '0;
            div_cnt_q  <= '0;
            ce_q       <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            base_cnt_q <= base_cnt_d;
            div_cnt_q  <= div_cnt_d;
            ce_q       <= ce_d;
        end
    end

    assign ce = ce_q;

endmodule

// File: rtl/clk_reset_ce_gen.sv
// Holds the core in reset until the PLL lock has been stable for LOCK_WAIT cycles, then
// releases a registered reset and runs the clock-enable divider.
module clk_reset_ce_gen
    import clk_gen_pkg::*;
#(
    parameter int LOCK_WAIT = LOCK_WAIT_DEF,
    parameter int BASE_DIV  = BASE_DIV_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    clk_reset_ce_gen_if.master    bus
);

    localparam int            WW        = cnt_width(LOCK_WAIT);
    localparam logic [WW-1:0] WAIT_LAST = WW'(LOCK_WAIT - 1);

    logic [1:0]    sync_q, sync_d;
    logic          locked_s;
    state_e        state_q, state_d;
    logic [WW-1:0] wait_cnt_q, wait_cnt_d;
    logic          sys_rst_q, sys_rst_d;
    ce_t           ce;

    // locked is asynchronous to clk, so it goes through two flops before it is used.
    assign sync_d   = {sync_q[0], bus.locked};
    assign locked_s = sync_q[1];

    // Loss of lock takes priority over a soft-reset request in every state.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        unique case (state_q)
            HOLD: begin
                wait_cnt_d = '0;
                if (locked_s && !bus.ext_rst) state_d = WAIT;
            end
            WAIT: begin
                if (!locked_s)                     state_d    = HOLD;
                else if (bus.ext_rst)              wait_cnt_d = '0;
                else if (wait_cnt_q == WAIT_LAST)  state_d    = RUN;
                else                               wait_cnt_d = wait_cnt_q + 1'b1;
            end
            RUN: begin
                if (!locked_s) begin
                    state_d = HOLD;
                end else if (bus.ext_rst) begin
                    state_d    = WAIT;
                    wait_cnt_d = '0;
                end
            end
            default: state_d = HOLD;
        endcase
        sys_rst_d = (state_d != RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q     <= '0;
            state_q    <= HOLD;
            wait_cnt_q <= '0;
            sys_rst_q  <= 1'b1;
        end else begin
            sync_q     <= sync_d;
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            sys_rst_q  <= sys_rst_d;
        end
    end

    ce_divider #(
        .BASE_DIV (BASE_DIV)
    ) u_ce_divider (
        .clk (clk),
        .rst (rst),
        .run (~sys_rst_d),
        .ce  (ce)
    );

    assign bus.sys_rst = sys_rst_q;
    assign bus.ce_16m  = ce.ce_16m;
    assign bus.ce_8m   = ce.ce_8m;
    assign bus.ce_4m   = ce.ce_4m;
    assign bus.ce_2m   = ce.ce_2m;
    assign bus.ce_1m   = ce.ce_1m;

endmodule

// File: tb/tb_clk_reset_ce_gen.sv
// Directed bench for clk_reset_ce_gen with LOCK_WAIT=16, BASE_DIV=6; expected enable
// patterns are queued when a run phase starts and popped as each cycle is sampled.
module tb_clk_reset_ce_gen;

    localparam int LOCK_WAIT = 16;
    localparam int BASE_DIV  = 6;

    logic clk = 1'b0;
    logic rst;

    clk_reset_ce_gen_if bus ();

    clk_reset_ce_gen #(
        .LOCK_WAIT (LOCK_WAIT),
        .BASE_DIV  (BASE_DIV)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          passed = 0;
    int          fails  = 0;
    logic [4:0]  exp_q[$];
    int          cnt[5];
    int          misalign;

    function automatic logic [4:0] ce_vec();
        return {bus.ce_1m, bus.ce_2m, bus.ce_4m, bus.ce_8m, bus.ce_16m};
    endfunction

    // Expected enables in run cycle k, with k=0 the first cycle where sys_rst is low.
    function automatic logic [4:0] exp_ce(input int k);
        logic [4:0] v;
        int         p;
        v = '0;
        if (k % BASE_DIV == BASE_DIV - 1) begin
            p    = k / BASE_DIV;
            v[0] = 1'b1;
            v[1] = (p % 2  == 1);
            v[2] = (p % 4  == 3);
            v[3] = (p % 8  == 7);
            v[4] = (p % 16 == 15);
        end
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts clk edges until sys_rst falls, checking the enables stay quiet meanwhile.
    task automatic wait_release(input string tag, input int lo, input int hi);
        int n;
        int ce_seen;
        n       = 0;
        ce_seen = 0;
        while (bus.sys_rst === 1'b1 && n < hi + 5) begin
            tick();
            n++;
            if (bus.sys_rst === 1'b1 && ce_vec() !== 5'b0) ce_seen++;
        end
        check({tag, " release_latency_in_window"}, 32'(n >= lo && n <= hi), 32'd1);
        check({tag, " no_ce_in_reset"}, 32'(ce_seen), 32'd0);
    endtask

    // Entered on cycle k=0 of a run; leaves the bench sampled at k=n-1.
    task automatic run_phase(input string tag, input int n);
        logic [4:0] e;
        logic [4:0] v;
        int         rst_bad;
        rst_bad  = 0;
        misalign = 0;
        for (int j = 0; j < 5; j++) cnt[j] = 0;
        for (int i = 0; i < n; i++) exp_q.push_back(exp_ce(i));
        for (int i = 0; i < n; i++) begin
            if (i > 0) tick();
            e = exp_q.pop_front();
            v = ce_vec();
            check($sformatf("%s ce k=%0d", tag, i), 32'(v), 32'(e));
            if (bus.sys_rst !== 1'b0) rst_bad++;
            for (int j = 0; j < 5; j++) if (v[j]) cnt[j]++;
            for (int j = 1; j < 5; j++) if (v[j] && !v[j-1]) misalign++;
        end
        check({tag, " sys_rst_stays_low"}, 32'(rst_bad), 32'd0);
        check({tag, " slower_ce_coincident"}, 32'(misalign), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int bad;

        rst         = 1'b1;
        bus.locked  = 1'b0;
        bus.ext_rst = 1'b0;
        repeat (3) tick();
        check("reset sys_rst", 32'(bus.sys_rst), 32'd1);
        check("reset ce", 32'(ce_vec()), 32'd0);

        // Power-up: lock arrives around edge 10 after reset release.
        #2 rst = 1'b0;
        repeat (10) tick();
        check("hold_without_lock sys_rst", 32'(bus.sys_rst), 32'd1);
        bus.locked = 1'b1;
        wait_release("powerup", 17, 19);

        run_phase("steady", 192);
        check("steady ce_16m count", 32'(cnt[0]), 32'd32);
        check("steady ce_8m count",  32'(cnt[1]), 32'd16);
        check("steady ce_4m count",  32'(cnt[2]), 32'd8);
        check("steady ce_2m count",  32'(cnt[3]), 32'd4);
        check("steady ce_1m count",  32'(cnt[4]), 32'd2);

        // Lock lost for three cycles during RUN.
        bus.locked = 1'b0;
        n = 0;
        while (bus.sys_rst === 1'b0 && n < 6) begin
            tick();
            n++;
        end
        check("lock_drop reset_latency", 32'(n >= 1 && n <= 3), 32'd1);
        check("lock_drop ce", 32'(ce_vec()), 32'd0);
        for (int i = n; i < 3; i++) tick();
        bus.locked = 1'b1;
        wait_release("relock", 17, 19);
        run_phase("relock_run", 24);

        // One-cycle soft reset in RUN.
        bus.ext_rst = 1'b1;
        tick();
        bus.ext_rst = 1'b0;
        check("ext_rst sys_rst_next_cycle", 32'(bus.sys_rst), 32'd1);
        check("ext_rst ce", 32'(ce_vec()), 32'd0);
        n = 1;
        for (int i = 0; i < 40 && bus.sys_rst === 1'b1; i++) begin
            tick();
            if (bus.sys_rst === 1'b1) n++;
        end
        check("ext_rst high_cycles", 32'(n), 32'd16);
        run_phase("ext_run", 48);

        // Lock glitch while waiting, landing at wait_cnt=10.
        bus.locked = 1'b0;
        for (int i = 0; i < 6 && bus.sys_rst === 1'b0; i++) tick();
        check("pre_glitch hold", 32'(bus.sys_rst), 32'd1);
        repeat (4) tick();
        bus.locked = 1'b1;
        bad = 0;
        for (int i = 0; i < 11; i++) begin
            tick();
            if (bus.sys_rst !== 1'b1) bad++;
        end
        bus.locked = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (bus.sys_rst !== 1'b1) bad++;
        end
        bus.locked = 1'b1;
        check("glitch no_early_release", 32'(bad), 32'd0);
        wait_release("glitch", 17, 19);
        run_phase("glitch_run", 12);

        // Async reset between edges, right on a 16M/8M enable cycle.
        check("pre_async ce_16m", 32'(bus.ce_16m), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async sys_rst", 32'(bus.sys_rst), 32'd1);
        check("async ce", 32'(ce_vec()), 32'd0);
        repeat (2) tick();
        #2 rst = 1'b0;
        wait_release("post_rst", 17, 19);
        run_phase("post_rst_run", 12);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/clk_reset_ce_gen.md
Name: clk_reset_ce_gen

Overview:
Sits directly downstream of the 96 MHz system PLL and consumes its output clock and `locked` flag.
- Holds the core in reset until `locked` has been stable for a programmable time.
- Releases a clean registered system reset.
- Generates phase-aligned single-cycle clock enables (16/8/4/2/1 MHz) that drive the BBC Micro core's CPU, video and peripheral timing.
- Any loss of lock or external reset request drops the core straight back into reset.

Parameters:
- LOCK_WAIT, 1024, clk cycles `locked_s` must stay high before `sys_rst` deasserts (≥2).
- BASE_DIV, 6, clk cycles per `ce_16m` period (96 MHz / 6 = 16 MHz); ≥2.

Ports:
- clk  in  1  96 MHz clock from PLL outclk_0.
- rst  in  1  asynchronous active-high reset (also tie PLL rst source).
- locked  in  1  PLL lock flag; treated as asynchronous to clk.
- ext_rst  in  1  synchronous active-high soft reset request (menu/HPS).
- sys_rst  out  1  registered active-high core reset.
- ce_16m  out  1  one-clk pulse every BASE_DIV cycles.
- ce_8m  out  1  one-clk pulse every 2*BASE_DIV cycles, coincident with `ce_16m`.
- ce_4m  out  1  one-clk pulse every 4*BASE_DIV cycles, coincident with `ce_8m`.
- ce_2m  out  1  one-clk pulse every 8*BASE_DIV cycles, coincident with `ce_4m`.
- ce_1m  out  1  one-clk pulse every 16*BASE_DIV cycles, coincident with `ce_2m`.

Behaviour:
- Reset values (`rst`=1): `sys_rst`=1, all `ce_*`=0, state=HOLD, counters=0, sync flops=0.
- `locked` passes through a 2-flop synchronizer, giving `locked_s` (2-cycle latency).
- State HOLD:
  - `sys_rst`=1, enables 0.
  - `locked_s`=1 and `ext_rst`=0 → WAIT, `wait_cnt` cleared.
- State WAIT:
  - `sys_rst`=1, enables 0, `wait_cnt` increments each cycle.
  - `locked_s`=0 → HOLD.
  - `ext_rst`=1 → `wait_cnt` cleared, remain WAIT.
  - `wait_cnt`==LOCK_WAIT-1 → RUN.
- State RUN:
  - `sys_rst`=0.
  - `locked_s`=0 → HOLD, with `sys_rst`=1 on the next edge.
  - `ext_rst`=1 → WAIT.
  - Both true at once → HOLD wins.
- `sys_rst` is registered from the state: it is low exactly in the cycles where the state register is RUN.
- Enable generation, RUN only:
  - `base_cnt` (0..BASE_DIV-1) and 4-bit `div_cnt` are cleared on any entry to RUN.
  - Let cycle 0 be the first cycle with `sys_rst`=0.
  - `ce_16m`=1 in cycles k where k mod BASE_DIV == BASE_DIV-1.
  - On each `ce_16m`, `div_cnt` increments and wraps 15→0.
  - `ce_8m` = `ce_16m` & `div_cnt[0]`.
  - `ce_4m` = `ce_16m` & (`div_cnt[1:0]`==3).
  - `ce_2m` = `ce_16m` & (`div_cnt[2:0]`==7).
  - `ce_1m` = `ce_16m` & (`div_cnt`==15).
  - `div_cnt` is the value before that cycle's increment.
  - All `ce_*` outputs are registered and aligned with each other as above.
  - For BASE_DIV=6: `ce_16m` at 5, 11, 17…; `ce_8m` at 11, 23…; `ce_4m` at 23, 47…; `ce_2m` at 47…; `ce_1m` at 95, 191….
- Leaving RUN forces all `ce_*` to 0 in the same edge that sets `sys_rst`. No partial pulse follows.
- `rst` asserted mid-operation clears everything asynchronously. Recovery then restarts from HOLD.
- `locked` glitch shorter than 1 clk may be missed by the synchronizer; anything registered as `locked_s`=0 restarts the full LOCK_WAIT.
- `wait_cnt` width is clog2(LOCK_WAIT); `base_cnt` width is clog2(BASE_DIV); no overflow is possible since both compare-and-clear.

Decomposition:
- Shared package `clk_gen_pkg`:
  - state enum {HOLD, WAIT, RUN};
  - default constants LOCK_WAIT_DEF=1024, BASE_DIV_DEF=6.
- One natural sub-module, `ce_divider`:
  - holds `base_cnt` and `div_cnt` and the `ce_*` output registers;
  - inputs clk, rst, run (clear when 0).
- Synchronizer and state machine stay in the top.

Test Plan (LOCK_WAIT=16, BASE_DIV=6):
- Power-up: `rst` pulse, `locked` rises at clk edge 10 → `sys_rst` falls 2+16 cycles later ±1 and stays low; no `ce_*` before that.
- Steady run for 192 cycles → `ce_16m` 32 pulses at k=5,11…; `ce_8m` 16; `ce_4m` 8; `ce_2m` 4; `ce_1m` 2 at k=95, 191; every slower pulse coincides with `ce_16m`.
- `locked` drops for 3 cycles during RUN → `sys_rst`=1 within 3 cycles of the drop, all `ce_*` 0; after `locked` returns, `sys_rst` low again after 2+16 cycles and `ce_16m` restarts at k=5.
- `ext_rst` one-cycle pulse in RUN → `sys_rst` high next cycle for 16 cycles, then low; the divider phase restarts from k=0.
- `locked` toggles in WAIT at `wait_cnt`=10 → back to HOLD; `sys_rst` never deasserts until a fresh 16 stable cycles elapse.
- Async `rst` asserted mid-RUN between clk edges → `sys_rst`=1 and `ce_*`=0 immediately (combinationally via async clear), without waiting for the next clk edge.
